// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative shift-add multiplier with HI/LO multiply-accumulate.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1010;
  localparam logic [3:0] OP_SEQ = 4'b1011;
  localparam logic [3:0] OP_NOT = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    WB
  } state_t;

  state_t             state;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               sgn;
  logic               acc;

  logic               accept;
  logic               mul_req;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   corr;
  logic [2*WIDTH-1:0] acc_sum;

  assign busy     = (state != IDLE);
  assign in_ready = ~busy;
  assign zero     = (result == '0);
  assign accept   = in_valid & in_ready & ~flush;
  assign mul_req  = md_op[1] | (alu_ctrl == OP_MUL);

  always_comb begin
    alu_res = '0;
    unique case (alu_ctrl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SLL:  alu_res = b << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_NOT:  alu_res = ~a;
      default: alu_res = '0;
    endcase
  end

  // Unsigned shift-add step; signed operands are corrected in FIX by
  // subtracting the sign-bit weighted cross terms from the upper half.
  assign step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + {1'b0, (prod[0] ? op_a : {WIDTH{1'b0}})};
  assign corr     = (op_a[WIDTH-1] ? op_b : {WIDTH{1'b0}})
                  + (op_b[WIDTH-1] ? op_a : {WIDTH{1'b0}});
  assign acc_sum  = {hi, lo} + prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      prod      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sgn       <= 1'b0;
      acc       <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        count <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept && mul_req) begin
              op_a  <= a;
              op_b  <= b;
              prod  <= {{WIDTH{1'b0}}, b};
              count <= '0;
              sgn   <= (md_op != 2'b11);
              acc   <= md_op[1];
              state <= MUL;
            end else if (accept) begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end
          MUL: begin
            prod  <= {step_sum, prod[WIDTH-1:1]};
            count <= count + 1'b1;
            if (count == SHW'(WIDTH-1)) begin
              count <= '0;
              state <= FIX;
            end
          end
          FIX: begin
            if (sgn)
              prod[2*WIDTH-1:WIDTH] <= prod[2*WIDTH-1:WIDTH] - corr;
            state <= WB;
          end
          WB: begin
            if (acc) begin
              hi     <= acc_sum[2*WIDTH-1:WIDTH];
              lo     <= acc_sum[WIDTH-1:0];
              result <= acc_sum[WIDTH-1:0];
            end else begin
              result <= prod[WIDTH-1:0];
            end
            out_valid <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level reference model checked
// every cycle, directed corner cases, then randomized traffic.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_ctrl;
  logic [1:0]    md_op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [4:0]    shamt;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .md_op(md_op),
    .a(a), .b(b), .shamt(shamt),
    .flush(flush),
    .out_valid(out_valid), .result(result),
    .zero(zero), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model state
  int           m_rem;
  logic [W-1:0] m_a, m_b, m_hi, m_lo, m_res;
  logic [1:0]   m_kind;
  logic         m_valid;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c,
      input logic [W-1:0] x, input logic [W-1:0] y, input int sh);
    logic [W-1:0] ones;
    ones = '1;
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0100: return x ^ y;
      4'b0101: return y >> sh;
      4'b0111: return (y >> sh) | (y[W-1] ? ~(ones >> sh) : '0);
      4'b1000: return y << sh;
      4'b1010: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 1 : 0;
      4'b1011: return (x == y) ? 1 : 0;
      4'b1100: return ~x;
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic [63:0] p, s;
    if (rst) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_res = 0; m_valid = 0;
      return;
    end
    m_valid = 0;
    if (m_rem > 0) begin
      if (flush) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_kind == 2'b11) p = {32'b0, m_a} * {32'b0, m_b};
          else p = {{32{m_a[31]}}, m_a} * {{32{m_b[31]}}, m_b};
          if (m_kind[1]) begin
            s = {m_hi, m_lo} + p;
            m_hi = s[63:32];
            m_lo = s[31:0];
            m_res = m_lo;
          end else m_res = p[31:0];
          m_valid = 1;
        end
      end
    end else if (in_valid && !flush) begin
      if (md_op[1] || alu_ctrl == 4'b0011) begin
        m_rem  = W + 2;
        m_a    = a;
        m_b    = b;
        m_kind = md_op[1] ? md_op : 2'b00;
      end else begin
        m_res   = ref_alu(alu_ctrl, a, b, int'(shamt));
        m_valid = 1;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_rem > 0);
    chk("in_ready", in_ready, m_rem == 0);
    chk("result", result, m_res);
    chk("zero", zero, m_res == 0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic op(input logic [3:0] c, input logic [1:0] md,
                    input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [4:0] sh);
    alu_ctrl = c; md_op = md; a = x; b = y; shamt = sh;
    in_valid = 1;
    cycle();
    in_valid = 0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  int n;
  logic seen;
  logic [3:0] codes [14] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h3, 4'h4, 4'h5,
                             4'h7, 4'h8, 4'hA, 4'hB, 4'hC, 4'hF, 4'h9};

  initial begin
    rst = 1; in_valid = 0; alu_ctrl = 0; md_op = 0;
    a = 0; b = 0; shamt = 0; flush = 0;
    m_rem = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
    m_res = 0; m_kind = 0; m_valid = 0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    rst = 0;
    cycle();

    op(4'b0010, 2'b00, 32'h7FFF_FFFF, 32'h1, 0);
    chk("add_res", result, 32'h8000_0000);
    chk("add_zero", zero, 0);
    chk("add_valid", out_valid, 1);
    chk("add_model", m_res, 32'h8000_0000);
    cycle();
    chk("valid_pulse", out_valid, 0);
    op(4'b0110, 2'b00, 5, 5, 0);
    chk("sub_zero", zero, 1);
    op(4'b0111, 2'b00, 0, 32'h8000_0000, 4);
    chk("sra_res", result, 32'hF800_0000);
    op(4'b1010, 2'b00, 32'hFFFF_FFFF, 1, 0);
    chk("slt_res", result, 1);
    op(4'b1011, 2'b00, 3, 3, 0);
    chk("seq_res", result, 1);
    op(4'b1111, 2'b00, 32'h1234, 32'h5678, 3);
    chk("bad_code", result, 0);
    chk("bad_valid", out_valid, 1);

    op(4'b0011, 2'b00, 32'hFFFF_FFFE, 3, 0);
    wait_valid("mul", n);
    chk("mul_lat", n, 34);
    chk("mul_res", result, 32'hFFFF_FFFA);
    chk("mul_busy", busy, 0);
    chk("mul_hi", hi, 0);
    chk("mul_lo", lo, 0);

    op(4'b0000, 2'b11, 32'hFFFF_FFFF, 1, 0);
    wait_valid("maddu0", n);
    op(4'b0000, 2'b11, 1, 1, 0);
    wait_valid("maddu1", n);
    chk("maddu_hi", hi, 1);
    chk("maddu_lo", lo, 0);
    chk("maddu_res", result, 0);
    op(4'b0000, 2'b10, 32'hFFFF_FFFF, 1, 0);
    wait_valid("madd", n);
    chk("madd_hi", hi, 0);
    chk("madd_lo", lo, 32'hFFFF_FFFF);
    chk("madd_model", m_lo, 32'hFFFF_FFFF);

    // in_valid held through a multiply
    alu_ctrl = 4'b0011; md_op = 0; a = 5; b = 6; in_valid = 1;
    cycle();
    alu_ctrl = 4'b0010; a = 100; b = 20;
    wait_valid("b2b", n);
    chk("b2b_lat", n, 34);
    chk("b2b_mul", result, 30);
    chk("b2b_ready", in_ready, 1);
    cycle();
    chk("b2b_add", result, 120);
    chk("b2b_valid", out_valid, 1);
    in_valid = 0;
    cycle();

    alu_ctrl = 4'b0010; a = 1; b = 1; in_valid = 1; flush = 1;
    cycle();
    chk("flush_idle", out_valid, 0);
    in_valid = 0; flush = 0;

    op(4'b0000, 2'b10, 7, 9, 0);
    repeat (10) cycle();
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      cycle();
      if (out_valid) seen = 1;
    end
    chk("flush_nov", seen, 0);
    chk("flush_hi", hi, 0);
    chk("flush_lo", lo, 32'hFFFF_FFFF);

    op(4'b0000, 2'b10, 3, 3, 0);
    repeat (15) cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rstm_hi", hi, 0);
    chk("rstm_lo", lo, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_zero", zero, 1);
    chk("rstm_ready", in_ready, 1);

    repeat (4000) begin
      in_valid = ($urandom_range(0, 9) < 6);
      alu_ctrl = codes[$urandom_range(0, 13)];
      md_op    = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom);
      a        = $urandom;
      b        = ($urandom_range(0, 3) == 0) ? a : $urandom;
      shamt    = 5'($urandom);
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
